// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the i-cache/d-cache memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int BLOCK_W_DEF = 128;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_t last,
    output logic   gnt_i,
    output logic   gnt_d
);

    assign gnt_i = req_i && (!req_d || last == GRANT_D);
    assign gnt_d = req_d && (!req_i || last == GRANT_I);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block memory port between the i-cache and d-cache miss paths,
// one transaction in flight, with saturating per-requester grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic [CNT_W-1:0]   i_grant_count,
    output logic [CNT_W-1:0]   d_grant_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t         state_q, state_d;
    grant_t             grant_q, grant_d;
    grant_t             last_q, last_d;
    logic               first_q, first_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]   i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;

    logic gnt_i, gnt_d;
    logic serving, releasing;

    rr_pick2 u_pick (
        .req_i (i_read),
        .req_d (d_read | d_write),
        .last  (last_q),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        first_d = first_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_d) begin
                    // read+write together is a writeback
                    grant_d = GRANT_D;
                    we_d    = d_write;
                    addr_d  = d_address;
                    wdata_d = d_writedata;
                    first_d = 1'b1;
                    state_d = ST_SERVE_D;
                end else if (gnt_i) begin
                    grant_d = GRANT_I;
                    we_d    = 1'b0;
                    addr_d  = i_address;
                    first_d = 1'b1;
                    state_d = ST_SERVE_I;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                // memory has not seen the strobe yet on the first edge
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!mem_busywait) begin
                    if (!we_q) rdata_d = mem_readdata;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                last_d = grant_q;
                if (grant_q == GRANT_I) begin
                    if (i_cnt_q != '1) i_cnt_d = i_cnt_q + CNT_ONE;
                end else begin
                    if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_ONE;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_I;
            last_q  <= GRANT_I;
            first_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            first_q <= first_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
        end
    end

    assign serving   = (state_q == ST_SERVE_I) || (state_q == ST_SERVE_D);
    assign releasing = (state_q == ST_RELEASE);

    // strobes are decoded from state so an async reset drops them at once
    assign mem_read      = serving && !we_q;
    assign mem_write     = serving && we_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;

    assign i_busywait = i_read && !(releasing && grant_q == GRANT_I);
    assign d_busywait = (d_read || d_write) && !(releasing && grant_q == GRANT_D);

    assign i_readdata    = rdata_q;
    assign d_readdata    = rdata_q;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level ownership model.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_address, d_address;
    logic [BW-1:0] d_writedata, mem_readdata;
    logic          mem_busywait;
    logic [BW-1:0] i_readdata, d_readdata, mem_writedata;
    logic          i_busywait, d_busywait, mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [CW-1:0] i_grant_count, d_grant_count;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    // Reference: who owns the port (0 none, 1 I, 2 D), whether this is the
    // hand-back cycle, and what the owner asked for.
    logic [1:0]    m_own;
    logic          m_rel, m_first, m_lastd, m_wr;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_rdata;
    logic [CW-1:0] m_ci, m_cd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_own <= 0; m_rel <= 0; m_first <= 0; m_lastd <= 0; m_wr <= 0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_ci <= '0; m_cd <= '0;
        end else if (m_rel) begin
            if (m_own == 2'd1 && m_ci != {CW{1'b1}}) m_ci <= m_ci + CW'(1);
            if (m_own == 2'd2 && m_cd != {CW{1'b1}}) m_cd <= m_cd + CW'(1);
            m_lastd <= (m_own == 2'd2);
            m_own   <= 0;
            m_rel   <= 0;
        end else if (m_own != 0) begin
            if (m_first) m_first <= 0;
            else if (!mem_busywait) begin
                if (!m_wr) m_rdata <= mem_readdata;
                m_rel <= 1;
            end
        end else if ((d_read || d_write) && (!i_read || !m_lastd)) begin
            m_own <= 2'd2; m_wr <= d_write; m_addr <= d_address; m_wdata <= d_writedata; m_first <= 1;
        end else if (i_read) begin
            m_own <= 2'd1; m_wr <= 0; m_addr <= i_address; m_first <= 1;
        end
    end

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic compare_all();
        logic serving;
        serving = (m_own != 0) && !m_rel;
        chk("mem_read", BW'(mem_read), BW'(serving && !m_wr));
        chk("mem_write", BW'(mem_write), BW'(serving && m_wr));
        if (serving) chk("mem_address", BW'(mem_address), BW'(m_addr));
        if (serving && m_wr) chk("mem_writedata", mem_writedata, m_wdata);
        chk("i_busywait", BW'(i_busywait), BW'(i_read && !(m_rel && m_own == 2'd1)));
        chk("d_busywait", BW'(d_busywait), BW'((d_read || d_write) && !(m_rel && m_own == 2'd2)));
        chk("i_readdata", i_readdata, m_rdata);
        chk("d_readdata", d_readdata, m_rdata);
        chk("i_grant_count", BW'(i_grant_count), BW'(m_ci));
        chk("d_grant_count", BW'(d_grant_count), BW'(m_cd));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();
        chk("rst_addr", BW'(mem_address), '0);
        chk("rst_wdata", mem_writedata, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_read = 0; d_read = 0; d_write = 0;
        i_address = '0; d_address = '0; d_writedata = '0;
        mem_readdata = '0; mem_busywait = 1'b0;

        // single i-cache miss, memory busy 4 cycles
        do_reset();
        i_read = 1; i_address = 28'h0000010; mem_busywait = 1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) chk("t1_strobe", BW'(mem_read), BW'(1));
            if (k < 6) chk("t1_stall", BW'(i_busywait), BW'(1));
            if (k == 5) begin mem_busywait = 0; mem_readdata = {16{8'hA5}}; end
            if (k == 6) begin
                chk("t1_busy_low", BW'(i_busywait), BW'(0));
                chk("t1_data", i_readdata, {16{8'hA5}});
            end
            if (k == 7) begin
                chk("t1_busy_again", BW'(i_busywait), BW'(1));
                chk("t1_cnt", BW'(i_grant_count), BW'(1));
                i_read = 0;
            end
        end
        step();

        // contention from reset: D, I, D, I
        do_reset();
        i_read = 1; d_read = 1; i_address = 28'h20; d_address = 28'h30;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 1) chk("t2_first_d", BW'(mem_address), BW'(28'h30));
            if (k == 4) chk("t2_d1", BW'({d_grant_count, i_grant_count}), BW'({4'd1, 4'd0}));
            if (k == 5) chk("t2_then_i", BW'(mem_address), BW'(28'h20));
            if (k == 8) chk("t2_i1", BW'({d_grant_count, i_grant_count}), BW'({4'd1, 4'd1}));
        end
        chk("t2_end", BW'({d_grant_count, i_grant_count}), BW'({4'd2, 4'd2}));
        i_read = 0; d_read = 0;
        step();

        // read+write together is a write
        do_reset();
        d_write = 1; d_read = 1; d_address = 28'h00000FF; d_writedata = {8{16'h1234}};
        step();
        chk("t3_write", BW'({mem_write, mem_read}), BW'(2'b10));
        chk("t3_wdata", mem_writedata, {8{16'h1234}});
        step(); step();
        d_write = 0; d_read = 0;
        step();
        chk("t3_cnt", BW'(d_grant_count), BW'(1));

        // async reset while serving D
        do_reset();
        d_read = 1; d_address = 28'h44;
        repeat (4) step();
        mem_busywait = 1;
        step(); step();
        chk("t4_pre", BW'({mem_read, d_grant_count}), BW'({1'b1, 4'd1}));
        reset = 1'b1;
        #1;
        chk("t4_strobe_drop", BW'(mem_read), BW'(0));
        chk("t4_cnt_clr", BW'(d_grant_count), BW'(0));
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("t4_regrant", BW'({mem_read, mem_address}), BW'({1'b1, 28'h44}));
        mem_busywait = 0;
        step(); step();
        d_read = 0;
        step();

        // request dropped mid-serve still completes; pending I goes next
        do_reset();
        i_read = 1; i_address = 28'h55; d_read = 1; d_address = 28'h66; mem_busywait = 1;
        step();
        d_read = 0;
        step(); step();
        mem_busywait = 0;
        step();
        chk("t6_d_nostall", BW'(d_busywait), BW'(0));
        step();
        chk("t6_cnt", BW'(d_grant_count), BW'(1));
        step();
        chk("t6_i_next", BW'({mem_read, mem_address}), BW'({1'b1, 28'h55}));
        step(); step();
        i_read = 0;
        step();

        // counter saturation
        do_reset();
        i_read = 1; i_address = 28'h77;
        repeat (80) step();
        chk("t5_sat", BW'(i_grant_count), BW'({CW{1'b1}}));
        i_read = 0;
        step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 299) == 0);
            if (i_read && !i_busywait) i_read = $urandom_range(0, 1) == 0;
            else if (!i_read) begin
                i_read = $urandom_range(0, 2) == 0;
                i_address = AW'($urandom);
            end else if ($urandom_range(0, 29) == 0) i_read = 0;
            if ((d_read || d_write) && !d_busywait) begin
                d_read = 0; d_write = 0;
            end else if (!(d_read || d_write)) begin
                d_read  = $urandom_range(0, 2) == 0;
                d_write = $urandom_range(0, 3) == 0;
                d_address = AW'($urandom);
                d_writedata = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 29) == 0) begin
                d_read = 0; d_write = 0;
            end
            mem_busywait = $urandom_range(0, 1) == 1;
            mem_readdata = {$urandom, $urandom, $urandom, $urandom};
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
